// File: rtl/hazard_tracker_pkg.sv
// Shared types for the hazard tracker: forward-select codes, widths,
// the per-stage shadow record and the saturating Tnew decrement.
package hazard_tracker_pkg;

  localparam int ADDR_WP = 5;
  localparam int TNEW_WP = 2;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_RF = 2'd0;
  localparam fwd_t FWD_E  = 2'd1;
  localparam fwd_t FWD_M  = 2'd2;
  localparam fwd_t FWD_W  = 2'd3;

  typedef struct packed {
    logic [ADDR_WP-1:0] a3;
    logic [TNEW_WP-1:0] tnew;
    logic [ADDR_WP-1:0] rs;
    logic [ADDR_WP-1:0] rt;
  } stage_t;

  localparam stage_t STAGE_NONE = '0;

  function automatic logic [TNEW_WP-1:0] tnew_dec(
    input logic [TNEW_WP-1:0] t
  );
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_tracker_fwd_select.sv
// Priority pick of one register against up to three producers.
// Ports: r (register read), en (slot mask), a3/tnew per slot
// (slot 0 = E, 1 = M, 2 = W), sel (FWD_* code of nearest hit).
module fwd_select
  import hazard_tracker_pkg::*;
#(
  parameter int ADDR_W = ADDR_WP,
  parameter int TNEW_W = TNEW_WP
) (
  input  logic [ADDR_W-1:0]        r,
  input  logic [2:0]               en,
  input  logic [2:0][ADDR_W-1:0]   a3,
  input  logic [2:0][TNEW_W-1:0]   tnew,
  output fwd_t                     sel
);

  logic [2:0] hit;

  // $0 is hard-wired, so it is never a forwarding target.
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = en[i] && (r != '0) &&
               (r == a3[i]) && (tnew[i] == '0);
    end
  end

  always_comb begin
    if (hit[0])      sel = FWD_E;
    else if (hit[1]) sel = FWD_M;
    else if (hit[2]) sel = FWD_W;
    else             sel = FWD_RF;
  end

endmodule

// File: rtl/hazard_tracker.sv
// Hazard tracker: shadows E/M/W, computes D stall and fwd selects.
// Ports: clk, reset (async, high); D-stage hazard info in
// (Rs_D, Rt_D, isRead_*, Tuse_*, A3_D, Tnew_D); stall and
// fwd_{D_rs,D_rt,E_rs,E_rt,M_rt} out; stall_cnt counts stalled
// cycles when HAZARD_STALL_CNT_EN is defined, else it reads 0.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int ADDR_W = ADDR_WP,
  parameter int TNEW_W = TNEW_WP,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Rs_D,
  input  logic [ADDR_W-1:0] Rt_D,
  input  logic              isRead_Rs,
  input  logic              isRead_Rt,
  input  logic [TNEW_W-1:0] Tuse_Rs_D,
  input  logic [TNEW_W-1:0] Tuse_Rt_D,
  input  logic [ADDR_W-1:0] A3_D,
  input  logic [TNEW_W-1:0] Tnew_D,
  output logic              stall,
  output logic [1:0]        fwd_D_rs,
  output logic [1:0]        fwd_D_rt,
  output logic [1:0]        fwd_E_rs,
  output logic [1:0]        fwd_E_rt,
  output logic [1:0]        fwd_M_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_t e_q, m_q, w_q;
  stage_t e_d;

  logic stall_rs, stall_rt;

  // A source waits only when its producer's result arrives later
  // than the consumer needs it; W results are always ready.
  always_comb begin
    stall_rs = isRead_Rs && (Rs_D != '0) &&
      ((Rs_D == e_q.a3 && e_q.tnew > Tuse_Rs_D) ||
       (Rs_D == m_q.a3 && m_q.tnew > Tuse_Rs_D));
    stall_rt = isRead_Rt && (Rt_D != '0) &&
      ((Rt_D == e_q.a3 && e_q.tnew > Tuse_Rt_D) ||
       (Rt_D == m_q.a3 && m_q.tnew > Tuse_Rt_D));
    stall = stall_rs || stall_rt;
  end

  always_comb begin
    e_d = STAGE_NONE;
    if (!stall) begin
      e_d.a3   = A3_D;
      e_d.tnew = tnew_dec(Tnew_D);
      e_d.rs   = isRead_Rs ? Rs_D : '0;
      e_d.rt   = isRead_Rt ? Rt_D : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= STAGE_NONE;
      m_q <= STAGE_NONE;
      w_q <= STAGE_NONE;
    end else begin
      e_q <= e_d;
      m_q <= '{a3: e_q.a3, tnew: tnew_dec(e_q.tnew),
               rs: '0, rt: e_q.rt};
      w_q <= '{a3: m_q.a3, tnew: tnew_dec(m_q.tnew),
               rs: '0, rt: '0};
    end
  end

  logic [2:0][ADDR_W-1:0] all_a3;
  logic [2:0][TNEW_W-1:0] all_tnew;

  assign all_a3   = {w_q.a3, m_q.a3, e_q.a3};
  assign all_tnew = {w_q.tnew, m_q.tnew, e_q.tnew};

  fwd_select #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_fwd_d_rs (
    .r    (Rs_D),
    .en   (3'b111),
    .a3   (all_a3),
    .tnew (all_tnew),
    .sel  (fwd_D_rs)
  );

  fwd_select #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_fwd_d_rt (
    .r    (Rt_D),
    .en   (3'b111),
    .a3   (all_a3),
    .tnew (all_tnew),
    .sel  (fwd_D_rt)
  );

  // E consumers look only at M and W; slot 0 is masked off.
  fwd_select #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_fwd_e_rs (
    .r    (e_q.rs),
    .en   (3'b110),
    .a3   (all_a3),
    .tnew (all_tnew),
    .sel  (fwd_E_rs)
  );

  fwd_select #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_fwd_e_rt (
    .r    (e_q.rt),
    .en   (3'b110),
    .a3   (all_a3),
    .tnew (all_tnew),
    .sel  (fwd_E_rt)
  );

  fwd_select #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W)) u_fwd_m_rt (
    .r    (m_q.rt),
    .en   (3'b100),
    .a3   (all_a3),
    .tnew (all_tnew),
    .sel  (fwd_M_rt)
  );

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= '0;
    else if (stall) cnt_q <= cnt_q + 1'b1;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: MIPS hazard scenarios with
// hand-computed stall / forward-select expectations.
module tb_hazard_tracker;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  Rs_D, Rt_D, A3_D;
  logic        isRead_Rs, isRead_Rt;
  logic [1:0]  Tuse_Rs_D, Tuse_Rt_D, Tnew_D;
  logic        stall;
  logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;
  logic [31:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  hazard_tracker dut (
    .clk       (clk),
    .reset     (reset),
    .Rs_D      (Rs_D),
    .Rt_D      (Rt_D),
    .isRead_Rs (isRead_Rs),
    .isRead_Rt (isRead_Rt),
    .Tuse_Rs_D (Tuse_Rs_D),
    .Tuse_Rt_D (Tuse_Rt_D),
    .A3_D      (A3_D),
    .Tnew_D    (Tnew_D),
    .stall     (stall),
    .fwd_D_rs  (fwd_D_rs),
    .fwd_D_rt  (fwd_D_rt),
    .fwd_E_rs  (fwd_E_rs),
    .fwd_E_rt  (fwd_E_rt),
    .fwd_M_rt  (fwd_M_rt),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input int rs, input int rt, input bit rdrs,
                     input bit rdrt, input int tus, input int tut,
                     input int a3, input int tnew);
    Rs_D      = 5'(rs);
    Rt_D      = 5'(rt);
    isRead_Rs = rdrs;
    isRead_Rt = rdrt;
    Tuse_Rs_D = 2'(tus);
    Tuse_Rt_D = 2'(tut);
    A3_D      = 5'(a3);
    Tnew_D    = 2'(tnew);
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    // hazard-looking D inputs: reset state must still read clean
    drv(1, 2, 1, 1, 0, 0, 3, 3);
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_fwd_d_rs", fwd_D_rs, 0);
    chk("rst_fwd_e_rs", fwd_E_rs, 0);
    chk("rst_cnt", stall_cnt, 0);
    nop();
    #9;
    reset = 1'b0;
    tick();

    // lw $1 then add $2,$1,$3
    drv(0, 0, 1, 0, 1, 0, 1, 3);
    #1 chk("s1_lw_nostall", stall, 0);
    tick();
    drv(1, 3, 1, 1, 1, 1, 2, 2);
    #1 chk("s1_stall", stall, 1);
    tick();
    #1 chk("s1_release", stall, 0);
    chk("s1_fwd_d_rs", fwd_D_rs, 0);
    tick();
    nop();
    #1 chk("s1_fwd_e_rs", fwd_E_rs, 3);
    chk("s1_fwd_e_rt", fwd_E_rt, 0);
    chk("s1_cnt", stall_cnt, CNT_EN ? 1 : 0);

    // add $5 then beq $5,$0
    drv(7, 8, 1, 1, 1, 1, 5, 2);
    #1 chk("s2_add_nostall", stall, 0);
    tick();
    drv(5, 0, 1, 1, 0, 0, 0, 0);
    #1 chk("s2_stall", stall, 1);
    chk("s2_fwd_d_rt", fwd_D_rt, 0);
    tick();
    #1 chk("s2_release", stall, 0);
    chk("s2_fwd_d_rs", fwd_D_rs, 2);
    chk("s2_cnt", stall_cnt, CNT_EN ? 2 : 0);

    // jal then jr $31
    drv(0, 0, 0, 0, 0, 0, 31, 0);
    tick();
    drv(31, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("s3_stall", stall, 0);
    chk("s3_fwd_d_rs", fwd_D_rs, 1);

    // lw $4 then sw $4,0($6)
    drv(0, 0, 1, 0, 1, 0, 4, 3);
    #1 chk("s4_lw_nostall", stall, 0);
    tick();
    drv(6, 4, 1, 1, 1, 2, 0, 0);
    #1 chk("s4_sw_nostall", stall, 0);
    chk("s4_fwd_d_rt", fwd_D_rt, 0);
    tick();
    nop();
    #1 chk("s4_e_nostall", stall, 0);
    chk("s4_fwd_e_rt", fwd_E_rt, 0);
    tick();
    #1 chk("s4_fwd_m_rt", fwd_M_rt, 3);

    // ori $0,$0,5 then add reading $0
    drv(0, 0, 1, 0, 1, 0, 0, 2);
    tick();
    drv(0, 0, 1, 1, 1, 1, 3, 2);
    #1 chk("s5_stall", stall, 0);
    chk("s5_fwd_d_rs", fwd_D_rs, 0);
    chk("s5_fwd_d_rt", fwd_D_rt, 0);
    chk("s5_fwd_e_rs", fwd_E_rs, 0);
    chk("s5_fwd_m_rt", fwd_M_rt, 0);

    // two writers of $10: nearest stage wins
    drv(0, 0, 0, 0, 0, 0, 10, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 10, 1);
    tick();
    drv(10, 0, 1, 0, 1, 0, 0, 0);
    #1 chk("p_stall", stall, 0);
    chk("p_fwd_d_e_over_m", fwd_D_rs, 1);
    tick();
    nop();
    #1 chk("p_fwd_e_m_over_w", fwd_E_rs, 2);

    // lw $9, two nops, then D reads $9 from W
    drv(0, 0, 1, 0, 1, 0, 9, 3);
    tick();
    nop();
    tick();
    tick();
    drv(9, 9, 1, 1, 0, 0, 0, 0);
    #1 chk("w_stall", stall, 0);
    chk("w_fwd_d_rs", fwd_D_rs, 3);
    chk("w_fwd_d_rt", fwd_D_rt, 3);
    tick();
    nop();
    tick();

    // lw $1 then beq $1: two stall cycles, reset in the second
    drv(0, 0, 1, 0, 1, 0, 1, 3);
    tick();
    drv(1, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("s6_stall1", stall, 1);
    tick();
    #1 chk("s6_stall2", stall, 1);
    chk("s6_cnt", stall_cnt, CNT_EN ? 3 : 0);
    #1 reset = 1'b1;
    #1 chk("s6_rst_stall", stall, 0);
    chk("s6_rst_fwd_d_rs", fwd_D_rs, 0);
    chk("s6_rst_fwd_e_rs", fwd_E_rs, 0);
    chk("s6_rst_fwd_m_rt", fwd_M_rt, 0);
    chk("s6_rst_cnt", stall_cnt, 0);
    tick();
    reset = 1'b0;
    nop();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
